// File: rtl/prog_ctr_stack_if.sv
// Fetch-side control bus of prog_ctr_stack: launch, branch, call/return requests
// from decoder/ALU, and the program-counter / run-status results returned to fetch.
interface prog_ctr_stack_if #(
  parameter int A     = 10,
  parameter int OFFW  = 6,
  parameter int NPROG = 3
);
  localparam int IDXW = $clog2(NPROG + 2);

  logic            Start;
  logic            Halt;
  logic            BranchAbsEn;
  logic            BranchRelEn;
  logic            CallEn;
  logic            RetEn;
  logic            ALU_flag;
  logic [A-1:0]    AbsTarget;
  logic [OFFW-1:0] RelTarget;
  logic [A-1:0]    ProgCtr;
  logic [IDXW-1:0] ProgIdx;
  logic            Running;
  logic            StackOverflow;
  logic            StackUnderflow;

  modport master (
    output Start, Halt, BranchAbsEn, BranchRelEn, CallEn, RetEn, ALU_flag,
           AbsTarget, RelTarget,
    input  ProgCtr, ProgIdx, Running, StackOverflow, StackUnderflow
  );

  modport slave (
    input  Start, Halt, BranchAbsEn, BranchRelEn, CallEn, RetEn, ALU_flag,
           AbsTarget, RelTarget,
    output ProgCtr, ProgIdx, Running, StackOverflow, StackUnderflow
  );
endinterface

// File: rtl/prog_ctr_stack.sv
// Instruction-fetch program counter with multi-program launch, conditional
// absolute/relative branches, a return-address stack, halt and sticky stack-error flags.
module prog_ctr_stack #(
  parameter int A       = 10,
  parameter int OFFW    = 6,
  parameter int NPROG   = 3,
  parameter int PSTRIDE = 100,
  parameter int RASD    = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  prog_ctr_stack_if.slave bus
);

  localparam int IDXW = $clog2(NPROG + 2);
  localparam int SPW  = $clog2(RASD + 1);
  localparam int SAW  = (RASD > 1) ? $clog2(RASD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [A-1:0]    pc_q, pc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [0:0]      state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            start_r_q;
  logic [A-1:0]    stack_q [RASD];

  logic            start_rise, start_fall;
  logic            push_en;
  logic [A-1:0]    pc_inc, pc_rel, launch_pc, stack_top;

  assign start_rise = bus.Start & ~start_r_q;
  assign start_fall = start_r_q & ~bus.Start;
  assign pc_inc     = pc_q + 1'b1;
  assign pc_rel     = pc_q + {{(A-OFFW){bus.RelTarget[OFFW-1]}}, bus.RelTarget};
  assign launch_pc  = A'(idx_q - 1'b1) * A'(PSTRIDE);
  assign stack_top  = stack_q[SAW'(sp_q - 1'b1)];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d    = pc_q;
    idx_d   = idx_q;
    state_d = state_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    if (start_rise && idx_q != IDXW'(NPROG + 1)) idx_d = idx_q + 1'b1;

    if (start_fall) begin
      // A fall after more rises than programs parks the sequencer without moving the PC.
      if (idx_q >= IDXW'(1) && idx_q <= IDXW'(NPROG)) begin
        pc_d    = launch_pc;
        state_d = ST_RUN;
        sp_d    = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_RUN) begin
      if (bus.Halt) begin
        state_d = ST_IDLE;
      end else if (bus.RetEn) begin
        if (sp_q != '0) begin
          pc_d = stack_top;
          sp_d = sp_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.CallEn) begin
        pc_d = bus.AbsTarget;
        if (sp_q < SPW'(RASD)) begin
          push_en = 1'b1;
          sp_d    = sp_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.BranchAbsEn && !bus.ALU_flag) begin
        pc_d = bus.AbsTarget;
      end else if (bus.BranchRelEn && !bus.ALU_flag) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= '0;
      idx_q     <= '0;
      state_q   <= ST_IDLE;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      start_r_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      start_r_q <= bus.Start;
    end
  end

  // NOTE: the stack array has no reset; the pointer alone defines which entries are valid.
  always_ff @(posedge Clk) begin
    if (push_en) stack_q[SAW'(sp_q)] <= pc_inc;
  end

  assign bus.ProgCtr        = pc_q;
  assign bus.ProgIdx        = idx_q;
  assign bus.Running        = (state_q == ST_RUN);
  assign bus.StackOverflow  = ovf_q;
  assign bus.StackUnderflow = unf_q;

endmodule
